prog_sequencer: RTL

- Execution controller for the 4-bit-PC / 18-bit-ROM / core datapath of the processor top level.
- Replaces the free-running program counter.
- Produces the ROM address and a one-cycle execute strobe for the core, all in the CLK_50 domain, gated by the 1 s tick strobe.
- Adds run/pause, single-step, breakpoint, end-of-program wrap or halt, and an executed-instruction counter.

---
 rtl/proc_pkg.sv | 26 ++
 rtl/prog_sequencer_edge_sync.sv | 46 ++++
 rtl/prog_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the processor top level: sequencer state
// encodings, ROM word field positions and the default PC width.
package proc_pkg;

    // Default PC / ROM address width.
    localparam int unsigned PC_W = 4;

    // Executed-instruction counter width.
    localparam int unsigned CNT_W = 16;

    // ROM word layout (18-bit words).
    localparam int unsigned ROM_W   = 18;
    localparam int unsigned SEL_BIT = 17;
    localparam int unsigned OP_HI   = 16;
    localparam int unsigned OP_LO   = 15;
    localparam int unsigned IMM_HI  = 14;

    // Sequencer FSM state encodings.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/prog_sequencer_edge_sync.sv
// edge_sync: two-flop synchronizer followed by a rising-edge detector.
//
// Ports:
//   clk     in   sampling clock
//   rst_n   in   synchronous active-low reset
//   din     in   asynchronous level input
//   rise_c  out  combinational one-cycle pulse on a synchronized rising edge
//
// PREV_RST is the reset value of the edge-detect history flop. With it set
// to 1, an input held high through reset produces no edge.
module edge_sync #(
    parameter bit PREV_RST = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_c
);

    logic       sync1;
    logic       sync2;
    logic       prev;
    logic [1:0] fill;

    // Synchronizer chain plus history flop. The history flop keeps its reset
    // value until the chain holds a real sample of din, so the reset-forced
    // zeros in the chain are never mistaken for a low input level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= PREV_RST;
            fill  <= 2'b00;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            fill  <= {fill[0], 1'b1};
            if (fill[1]) begin
                prev <= sync2;
            end
        end
    end

    assign rise_c = sync2 & ~prev;

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: execution controller that drives the ROM address and a
// one-cycle execute strobe for the core, paced by the 1 s tick.
//
// Ports:
//   CLK_50     in   system clock
//   RST_N      in   synchronous active-low reset
//   tick       in   one-cycle strobe from the 1 s divider
//   run        in   run switch level (already synchronous)
//   step       in   raw step push-button level (asynchronous)
//   bp_en      in   breakpoint enable
//   bp_addr    in   breakpoint address
//   pc         out  ROM address
//   exec_en    out  one-cycle strobe; core latches rom_data when high
//   state      out  current FSM state (IDLE/RUN/PAUSE/HALT)
//   halted     out  high while in HALT
//   instr_cnt  out  executed instruction count, saturating
module prog_sequencer
    import proc_pkg::*;
#(
    parameter int unsigned AW        = PC_W,
    parameter int unsigned LAST_ADDR = 15,
    parameter bit          WRAP      = 1'b1
) (
    input  logic             CLK_50,
    input  logic             RST_N,
    input  logic             tick,
    input  logic             run,
    input  logic             step,
    input  logic             bp_en,
    input  logic [AW-1:0]    bp_addr,
    output logic [AW-1:0]    pc,
    output logic             exec_en,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [AW-1:0]    LAST_PC = AW'(LAST_ADDR);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    seq_state_t       state_q, state_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic             exec_q, exec_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_prev;

    logic             step_rise;
    logic             run_rise;
    logic             issue;
    logic             at_last;
    logic [AW-1:0]    pc_next;

    // Step button: synchronize and detect the press.
    edge_sync #(
        .PREV_RST (1'b1)
    ) u_step_sync (
        .clk    (CLK_50),
        .rst_n  (RST_N),
        .din    (step),
        .rise_c (step_rise)
    );

    assign run_rise = run & ~run_prev;

    // Address the sequencer moves to when the current word is issued.
    assign at_last = (pc_q == LAST_PC);
    assign pc_next = at_last ? (WRAP ? '0 : pc_q) : pc_q + AW'(1);

    // State and output registers.
    always_ff @(posedge CLK_50) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            exec_q   <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
            run_prev <= 1'b1;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            exec_q   <= exec_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
            run_prev <= run;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        exec_d   = 1'b0;
        cnt_d    = cnt_q;
        issue    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_RUN;
                end else if (step_rise) begin
                    issue = 1'b1;
                end
            end
            ST_RUN: begin
                // Dropping run wins over a coincident tick.
                if (!run) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    issue = 1'b1;
                    // Stop in front of the breakpoint word, not after it.
                    if (bp_en && (pc_next == bp_addr)) begin
                        state_d = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                // Resume needs a fresh run edge; a coincident step is dropped.
                if (run_rise) begin
                    state_d = ST_RUN;
                end else if (step_rise) begin
                    issue = 1'b1;
                end
            end
            ST_HALT: begin
                if (step_rise || run_rise) begin
                    pc_d    = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (issue) begin
            exec_d = 1'b1;
            pc_d   = pc_next;
            cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            if (at_last && !WRAP) begin
                state_d = ST_HALT;
            end
        end

        halted_d = (state_d == ST_HALT);
    end

    assign pc        = pc_q;
    assign exec_en   = exec_q;
    assign state     = state_q;
    assign halted    = halted_q;
    assign instr_cnt = cnt_q;

endmodule
